// File: rtl/nnrv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nnrv_pkg
// Purpose  : Shared types, constants and helpers for the nnrv unified RAM
//            and its boot loader.
// Contents : ld_state_t     - boot loader state encoding
//            WORD_SHIFT     - byte-address to word-index shift (8-byte words)
//            MASK_LO        - byte mask selecting the low 32-bit half
//            addr_in_range  - checks that no address bit above the array is set
// Revision : 1.0 - initial release
// ============================================================================
package nnrv_pkg;

    typedef enum logic [1:0] {
        LD_LO   = 2'd0,
        LD_HI   = 2'd1,
        LD_DONE = 2'd2
    } ld_state_t;

    localparam int         WORD_SHIFT = 3;
    localparam logic [7:0] MASK_LO    = 8'h0F;

    // True when the byte address falls inside a 2**depth_log2-word array.
    function automatic logic addr_in_range(input logic [63:0] addr,
                                           input int          depth_log2);
        return (addr >> (depth_log2 + WORD_SHIFT)) == 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nnrv_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : nnrv_ram_loader
// Purpose  : Boot loader. Packs pairs of 32-bit instruction beats into
//            64-bit words and writes them from word 0 upward.
// Ports    : i_clk, i_rst            clock, async active-high reset
//            i_ld_valid/o_ld_ready   beat handshake
//            i_ld_data, i_ld_last    beat payload and end-of-stream marker
//            o_ld_done, o_ld_err     sticky completion / overflow flags
//            o_busy                  loader still active
//            o_we/o_widx/o_wmask/o_wdata  write request to the array
// Revision : 1.0 - initial release
// ============================================================================
module nnrv_ram_loader
    import nnrv_pkg::*;
#(
    parameter int DEPTH_LOG2 = 12,
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH >> 3
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [31:0]           i_ld_data,
    input  logic                  i_ld_last,
    output logic                  o_ld_done,
    output logic                  o_ld_err,
    output logic                  o_busy,
    output logic                  o_we,
    output logic [DEPTH_LOG2-1:0] o_widx,
    output logic [MASK_WIDTH-1:0] o_wmask,
    output logic [DATA_WIDTH-1:0] o_wdata
);

    ld_state_t             r_state, w_state_nxt;
    logic [DEPTH_LOG2-1:0] r_ptr, w_ptr_nxt;
    logic [31:0]           r_hold_lo, w_hold_nxt;
    logic                  r_err, w_err_nxt;
    logic                  w_accept;

    assign o_ld_ready = (r_state == LD_LO) || (r_state == LD_HI);
    assign o_ld_done  = (r_state == LD_DONE);
    assign o_busy     = (r_state != LD_DONE);
    assign o_ld_err   = r_err;
    assign o_widx     = r_ptr;
    assign w_accept   = i_ld_valid && o_ld_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= LD_LO;
            r_ptr     <= '0;
            r_hold_lo <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_hold_lo <= w_hold_nxt;
            r_err     <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_hold_nxt  = r_hold_lo;
        w_err_nxt   = r_err;
        o_we        = 1'b0;
        o_wmask     = '0;
        o_wdata     = '0;
        case (r_state)
            LD_LO: begin
                if (w_accept) begin
                    if (i_ld_last) begin
                        // Odd beat count: commit the lone low half only.
                        o_we        = 1'b1;
                        o_wmask     = MASK_WIDTH'(MASK_LO);
                        o_wdata     = DATA_WIDTH'(i_ld_data);
                        w_state_nxt = LD_DONE;
                    end else begin
                        w_hold_nxt  = i_ld_data;
                        w_state_nxt = LD_HI;
                    end
                end
            end
            LD_HI: begin
                if (w_accept) begin
                    o_we    = 1'b1;
                    o_wmask = '1;
                    o_wdata = DATA_WIDTH'({i_ld_data, r_hold_lo});
                    if (i_ld_last) begin
                        w_state_nxt = LD_DONE;
                    end else if (r_ptr == '1) begin
                        // Array full with more beats pending: stop, no wrap.
                        w_err_nxt   = 1'b1;
                        w_state_nxt = LD_DONE;
                    end else begin
                        w_ptr_nxt   = r_ptr + 1'b1;
                        w_state_nxt = LD_LO;
                    end
                end
            end
            LD_DONE: begin
                w_state_nxt = LD_DONE;
            end
            default: begin
                w_state_nxt = LD_LO;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/nnrv_ram.sv
`default_nettype none
// ============================================================================
// Module   : nnrv_ram
// Purpose  : Unified 64-bit program/data memory with combinational masked
//            reads, byte-masked synchronous writes and a boot loader that
//            holds the core in reset (o_busy) until the image is streamed in.
// Ports    : i_clk, i_rst                       clock, async active-high reset
//            i_rd_addr/i_rd_en/i_rd_mask/o_rd_data  combinational read port
//            i_wr_addr/i_wr_en/i_wr_mask/i_wr_data  core write port
//            i_ld_* / o_ld_*                    boot loader stream + status
//            o_busy                             loader active
//            o_addr_err                         sticky out-of-range flag
// Revision : 1.0 - initial release
// ============================================================================
module nnrv_ram
    import nnrv_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int MASK_WIDTH = DATA_WIDTH >> 3,
    parameter int XLEN       = 64,
    parameter int DEPTH_LOG2 = 12
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [XLEN-1:0]       i_rd_addr,
    input  logic                  i_rd_en,
    input  logic [MASK_WIDTH-1:0] i_rd_mask,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic [XLEN-1:0]       i_wr_addr,
    input  logic                  i_wr_en,
    input  logic [MASK_WIDTH-1:0] i_wr_mask,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_ld_valid,
    output logic                  o_ld_ready,
    input  logic [31:0]           i_ld_data,
    input  logic                  i_ld_last,
    output logic                  o_ld_done,
    output logic                  o_ld_err,
    output logic                  o_busy,
    output logic                  o_addr_err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_ld_we;
    logic [DEPTH_LOG2-1:0] w_ld_idx;
    logic [MASK_WIDTH-1:0] w_ld_mask;
    logic [DATA_WIDTH-1:0] w_ld_data;

    logic                  w_rd_in_range, w_wr_in_range;
    logic [DEPTH_LOG2-1:0] w_rd_idx, w_wr_idx;
    logic                  w_core_wr_ok;

    logic                  w_we;
    logic [DEPTH_LOG2-1:0] w_widx;
    logic [MASK_WIDTH-1:0] w_wmask;
    logic [DATA_WIDTH-1:0] w_wdata;

    logic                  r_addr_err;

    nnrv_ram_loader #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_WIDTH (DATA_WIDTH),
        .MASK_WIDTH (MASK_WIDTH)
    ) u_loader (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ld_valid (i_ld_valid),
        .o_ld_ready (o_ld_ready),
        .i_ld_data  (i_ld_data),
        .i_ld_last  (i_ld_last),
        .o_ld_done  (o_ld_done),
        .o_ld_err   (o_ld_err),
        .o_busy     (o_busy),
        .o_we       (w_ld_we),
        .o_widx     (w_ld_idx),
        .o_wmask    (w_ld_mask),
        .o_wdata    (w_ld_data)
    );

    assign w_rd_in_range = addr_in_range(64'(i_rd_addr), DEPTH_LOG2);
    assign w_wr_in_range = addr_in_range(64'(i_wr_addr), DEPTH_LOG2);
    assign w_rd_idx      = i_rd_addr[DEPTH_LOG2+WORD_SHIFT-1:WORD_SHIFT];
    assign w_wr_idx      = i_wr_addr[DEPTH_LOG2+WORD_SHIFT-1:WORD_SHIFT];
    assign w_core_wr_ok  = i_wr_en && !o_busy && w_wr_in_range;

    // Read straight from the array: a same-cycle write is not forwarded.
    always_comb begin
        o_rd_data = '0;
        if (i_rd_en && w_rd_in_range) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (i_rd_mask[b]) begin
                    o_rd_data[b*8 +: 8] = r_mem[w_rd_idx][b*8 +: 8];
                end
            end
        end
    end

    // Loader wins; core writes are already gated off while it is busy.
    always_comb begin
        w_we    = 1'b0;
        w_widx  = '0;
        w_wmask = '0;
        w_wdata = '0;
        if (w_ld_we) begin
            w_we    = 1'b1;
            w_widx  = w_ld_idx;
            w_wmask = w_ld_mask;
            w_wdata = w_ld_data;
        end else if (w_core_wr_ok) begin
            w_we    = 1'b1;
            w_widx  = w_wr_idx;
            w_wmask = i_wr_mask;
            w_wdata = i_wr_data;
        end
    end

    // The array itself carries no reset.
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            for (int b = 0; b < MASK_WIDTH; b++) begin
                if (w_wmask[b]) begin
                    r_mem[w_widx][b*8 +: 8] <= w_wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr_err <= 1'b0;
        end else if ((i_rd_en && !w_rd_in_range) ||
                     (i_wr_en && !o_busy && !w_wr_in_range)) begin
            r_addr_err <= 1'b1;
        end
    end

    assign o_addr_err = r_addr_err;

endmodule
`default_nettype wire

// File: doc/nnrv_ram.md
# nnrv_ram

Unified 64-bit-wide program/data memory: the responder on the other end of the fetch stage's `o_ram_rd_*` read interface. It serves combinational reads to the core, has a byte-masked synchronous write port, and contains a boot loader. The boot loader streams 32-bit instruction beats into memory from address 0 before the core is released. It sits at top level beside the core, and its `o_busy` holds the core in reset.

## Interface
- DATA_WIDTH, 64, memory word width in bits.
- MASK_WIDTH, DATA_WIDTH>>3, one byte-enable bit per byte.
- XLEN, 64, address width.
- DEPTH_LOG2, 12, log2 of the number of words (4096 words = 32 KiB).
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-high.
- i_rd_addr  in  XLEN  byte address; word index = i_rd_addr[DEPTH_LOG2+2:3].
- i_rd_en  in  1  read enable.
- i_rd_mask  in  MASK_WIDTH  byte enables for the read.
- o_rd_data  out  DATA_WIDTH  read data.
- i_wr_addr  in  XLEN  byte address for core writes.
- i_wr_en  in  1  core write enable.
- i_wr_mask  in  MASK_WIDTH  byte enables for the write.
- i_wr_data  in  DATA_WIDTH  write data.
- i_ld_valid  in  1  loader beat valid.
- o_ld_ready  out  1  loader can accept a beat.
- i_ld_data  in  32  instruction beat.
- i_ld_last  in  1  marks the final beat.
- o_ld_done  out  1  load complete (sticky).
- o_ld_err  out  1  load overflowed memory (sticky).
- o_busy  out  1  loader active; the core must be held in reset.
- o_addr_err  out  1  sticky flag: out-of-range access seen.

## Operation
- **Read** (combinational):
  - o_rd_data = mem[word], with disabled bytes forced to zero.
  - i_rd_en=0 drives all zeros.
  - An address with any bit above DEPTH_LOG2+2 set is out of range: returns zero.
- **Core write**:
  - At the clock edge, bytes with i_wr_mask=1 are updated.
  - Out of range: dropped, and o_addr_err is set.
  - Core writes are ignored entirely while o_busy=1.
- **Same-word read and write in the same cycle**: the read returns the old contents. There is no bypass.
- **Memory array**: not reset. Only control state is reset.
- **Loader FSM**: states LD_LO, LD_HI, LD_DONE. Word pointer ptr[DEPTH_LOG2-1:0] and a 32-bit holding register hold_lo.
  - Reset → LD_LO, ptr=0.
  - A beat is accepted when i_ld_valid && o_ld_ready. o_ld_ready=1 in LD_LO and LD_HI.
  - LD_LO, !last: hold_lo ← data → LD_HI.
  - LD_LO, last: write mem[ptr] with mask 8'h0F, data in bits [31:0] → LD_DONE.
  - LD_HI: write mem[ptr] = {data, hold_lo} with mask 8'hFF, then ptr ← ptr+1.
    - Next state: last ? LD_DONE : LD_LO.
    - If ptr == 2^DEPTH_LOG2−1 and !last: o_ld_err ← 1 → LD_DONE. The pointer does not wrap.
  - LD_DONE: o_ld_ready=0 and o_ld_done=1 until reset.
  - o_busy = (state != LD_DONE).
- **Address error**: a read with i_rd_en=1 and an out-of-range address, or a dropped out-of-range write, sets o_addr_err at the next edge. It clears only on reset.

## Timing
- Read latency: 0 cycles (combinational).
  - The fetch stage captures o_rd_data at the same edge on which it changes its address.
- Write latency: data is visible to reads in the cycle after the write edge.
- Loader throughput: one beat per cycle. A full 64-bit word is committed on the LD_HI beat edge.
- o_ld_done, o_ld_err and o_busy change on the edge that accepts the final beat.
- Reset values:
  - o_ld_ready=1, o_ld_done=0, o_ld_err=0, o_busy=1, o_addr_err=0.
  - o_rd_data is combinational from the array and inputs.
- Reset mid-load: the FSM returns to LD_LO with ptr=0. Words already written remain in memory.

## Structure
- **nnrv_pkg** holds:
  - the loader state enum (LD_LO, LD_HI, LD_DONE);
  - the constants WORD_SHIFT=3 and MASK_LO=8'h0F;
  - the range-check helper function.
- **Sub-module nnrv_ram_loader**:
  - contains the FSM, ptr, hold_lo and the done/err flags;
  - outputs a write request (index, mask, data) to the array.
- **Top**: the array, read masking, write arbitration (loader has priority; core writes are gated by o_busy) and the addr_err flag.

## Test plan
- **Load 3 beats** 0x00000013, 0x00100093, 0x00200113 (last on the third) → mem[0]=0x00100093_00000013, mem[1] low half=0x00200113 with the upper bytes untouched. o_ld_done=1 and o_busy=0 on the edge after beat 3.
- **Read after load**, i_rd_addr=0x4, i_rd_mask=8'hFF, i_rd_en=1 → o_rd_data=0x00100093_00000013 in the same cycle. With i_rd_mask=8'hF0 → 0x00100093_00000000.
- **Core write** at address 0x8, mask 8'h3C, data 0x1122334455667788 → the next-cycle read shows only bytes 2..5 changed. Reading the same word in the write cycle returns the old value.
- **Out of range**: read at 0x8000 (DEPTH_LOG2=12) → 0. A write there is dropped, and o_addr_err=1 from the next cycle until reset.
- **Overflow**: stream 2·4096+1 beats with no last → o_ld_err=1 and o_ld_done=1 after beat 8192, and o_ld_ready=0 thereafter.
- **Assert i_rst during LD_HI** → o_ld_ready=1, o_busy=1 immediately. The next load restarts at word 0.
